// File: rtl/data_mem_mmio_if.sv
// Memory-stage data port bundle.
// Carries the store strobe, byte address, store data and load data.
interface data_mem_mmio_if;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;

   modport master (
      output MemWriteM,
      output ALUResultM,
      output WriteDataM,
      input  ReadDataM
   );

   modport slave (
      input  MemWriteM,
      input  ALUResultM,
      input  WriteDataM,
      output ReadDataM
   );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO block (LED, 64-bit cycle counter, byte TX FIFO).
// Loads are combinational so the Memory stage never stalls.
module data_mem_mmio #(
   parameter int DMEM_DEPTH = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   data_mem_mmio_if.slave   bus,
   output logic [31:0]      led_o,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready
);

   localparam int AW = $clog2(DMEM_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      OFF_LED    = 3'd0,
      OFF_CYCLO  = 3'd1,
      OFF_CYCHI  = 3'd2,
      OFF_TXDATA = 3'd3,
      OFF_TXSTAT = 3'd4,
      OFF_TXDROP = 3'd5,
      OFF_RSV0   = 3'd6,
      OFF_RSV1   = 3'd7
   } mmioOff_t;

   logic          ramSel;
   logic          mmioSel;
   logic [AW-1:0] ramIdx;
   mmioOff_t      mmioOff;

   assign ramSel  = ~bus.ALUResultM[31];
   assign mmioSel = bus.ALUResultM[31];
   assign ramIdx  = bus.ALUResultM[AW+1:2];
   assign mmioOff = mmioOff_t'(bus.ALUResultM[4:2]);

   // Byte offset and aliasing address bits carry no meaning here.
   logic unusedAddr;
   assign unusedAddr = ^{bus.ALUResultM[30:AW+2],
                         bus.ALUResultM[1:0]};

   logic ramWe;
   logic ledWe;
   logic pushReq;

   assign ramWe   = bus.MemWriteM & ramSel;
   assign ledWe   = bus.MemWriteM & mmioSel
                    & (mmioOff == OFF_LED);
   assign pushReq = bus.MemWriteM & mmioSel
                    & (mmioOff == OFF_TXDATA);

   logic [31:0] ram [DMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (ramWe) begin
         ram[ramIdx] <= bus.WriteDataM;
      end
   end

   logic [31:0] ledReg;
   logic [63:0] cycleCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ledReg   <= '0;
         cycleCnt <= '0;
      end else begin
         cycleCnt <= cycleCnt + 64'd1;
         if (ledWe) begin
            ledReg <= bus.WriteDataM;
         end
      end
   end

   assign led_o = ledReg;

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [PW:0]   count;
   logic [31:0]   dropCnt;
   logic          full;
   logic          empty;
   logic          pop;
   logic          pushOk;
   logic          drop;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign pop    = tx_valid & tx_ready;
   // A full FIFO still takes a byte when the head leaves on this edge.
   assign pushOk = pushReq & (~full | pop);
   assign drop   = pushReq & full & ~pop;

   always_ff @(posedge clk) begin
      if (pushOk) begin
         fifoMem[wrPtr] <= bus.WriteDataM[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= '0;
         dropCnt <= '0;
      end else begin
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
         end
         unique case ({pushOk, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            dropCnt <= dropCnt + 32'd1;
         end
      end
   end

   assign tx_valid = ~empty;
   assign tx_data  = fifoMem[rdPtr];

   logic [31:0] txStat;
   logic [31:0] mmioRd;

   assign txStat = {16'b0, 8'(count), 6'b0, full, empty};

   always_comb begin
      mmioRd = '0;
      unique case (mmioOff)
         OFF_LED:    mmioRd = ledReg;
         OFF_CYCLO:  mmioRd = cycleCnt[31:0];
         OFF_CYCHI:  mmioRd = cycleCnt[63:32];
         OFF_TXDATA: mmioRd = '0;
         OFF_TXSTAT: mmioRd = txStat;
         OFF_TXDROP: mmioRd = dropCnt;
         OFF_RSV0:   mmioRd = '0;
         OFF_RSV1:   mmioRd = '0;
      endcase
   end

   always_comb begin
      bus.ReadDataM = mmioRd;
      if (ramSel) begin
         bus.ReadDataM = ram[ramIdx];
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: RAM, LED, CYCLE, TX FIFO and reset.
// Inputs change on negedge; outputs are sampled 2 time units later.
module tb_data_mem_mmio;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_ready = 1'b0;
   logic [31:0] led_o;
   logic        tx_valid;
   logic [7:0]  tx_data;

   data_mem_mmio_if bus();

   data_mem_mmio #(.DMEM_DEPTH(1024), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .led_o(led_o), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] rdQ[$];
   logic [7:0]  txQ[$];

   localparam logic [31:0] A_LED  = 32'h8000_0000;
   localparam logic [31:0] A_CLO  = 32'h8000_0004;
   localparam logic [31:0] A_CHI  = 32'h8000_0008;
   localparam logic [31:0] A_TXD  = 32'h8000_000C;
   localparam logic [31:0] A_STAT = 32'h8000_0010;
   localparam logic [31:0] A_DROP = 32'h8000_0014;

   task automatic drive(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
      @(negedge clk);
      bus.MemWriteM  = we;
      bus.ALUResultM = a;
      bus.WriteDataM = d;
      tx_ready       = rdy;
      #2;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      bus.MemWriteM = 1'b0; bus.ALUResultM = '0; bus.WriteDataM = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0; bus.ALUResultM = A_CLO; #2;
      rdQ.push_back(32'h0); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL rst_cycle got %h exp %h", bus.ReadDataM, e); end
      checks++;
      if (led_o !== 32'h0) begin errors++;
         $display("FAIL rst_led got %h exp 0", led_o); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++;
         $display("FAIL rst_txvalid got %b exp 0", tx_valid); end
      bus.ALUResultM = A_STAT; #1;
      rdQ.push_back(32'h1); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL rst_stat got %h exp %h", bus.ReadDataM, e); end
   endtask

   task automatic test_ram();
      logic [31:0] e;
      drive(1'b1, 32'h10, 32'h1234_5678, 1'b0);
      drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      rdQ.push_back(32'h1234_5678); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_old got %h exp %h", bus.ReadDataM, e); end
      drive(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0);
      drive(1'b0, 32'h10, 32'h0, 1'b0);
      rdQ.push_back(32'hDEAD_BEEF); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_new got %h exp %h", bus.ReadDataM, e); end
      bus.ALUResultM = 32'h13; #1;
      rdQ.push_back(32'hDEAD_BEEF); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_byteoff got %h exp %h", bus.ReadDataM, e); end
      bus.ALUResultM = 32'h1010; #1;
      rdQ.push_back(32'hDEAD_BEEF); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_alias got %h exp %h", bus.ReadDataM, e); end
      bus.ALUResultM = 32'h20; #1;
      rdQ.push_back(32'hCAFE_F00D); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_word2 got %h exp %h", bus.ReadDataM, e); end
   endtask

   task automatic test_led();
      logic [31:0] e;
      drive(1'b1, A_LED, 32'hA5, 1'b0);
      checks++;
      if (led_o !== 32'h0) begin errors++;
         $display("FAIL led_early got %h exp 0", led_o); end
      drive(1'b0, A_LED, 32'h0, 1'b0);
      checks++;
      if (led_o !== 32'hA5) begin errors++;
         $display("FAIL led_out got %h exp a5", led_o); end
      rdQ.push_back(32'hA5); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL led_read got %h exp %h", bus.ReadDataM, e); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (led_o !== 32'h0) begin errors++;
         $display("FAIL led_rst got %h exp 0", led_o); end
   endtask

   task automatic test_cycle();
      logic [31:0] e;
      @(negedge clk);
      rst = 1'b0; bus.MemWriteM = 1'b0; bus.ALUResultM = A_CLO; #2;
      rdQ.push_back(32'd0); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL cyc_first got %h exp %h", bus.ReadDataM, e); end
      repeat (100) @(negedge clk);
      #2;
      rdQ.push_back(32'd100); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL cyc_100 got %0d exp %0d", bus.ReadDataM, e); end
      @(negedge clk);
      force dut.cycleCnt = 64'h0000_0000_FFFF_FFFE;
      #1;
      release dut.cycleCnt;
      #1;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) begin @(negedge clk); #2; end
         rdQ.push_back(32'hFFFF_FFFE + 32'(k));
         rdQ.push_back((k == 2) ? 32'd1 : 32'd0);
         bus.ALUResultM = A_CLO; #1;
         e = rdQ.pop_front(); checks++;
         if (bus.ReadDataM !== e) begin errors++;
            $display("FAIL cyc_lo%0d got %h exp %h", k, bus.ReadDataM, e); end
         bus.ALUResultM = A_CHI; #1;
         e = rdQ.pop_front(); checks++;
         if (bus.ReadDataM !== e) begin errors++;
            $display("FAIL cyc_hi%0d got %h exp %h", k, bus.ReadDataM, e); end
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] e;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, A_TXD, 32'h11 + 32'(i), 1'b0);
         txQ.push_back(8'h11 + 8'(i));
      end
      drive(1'b0, A_STAT, 32'h0, 1'b0);
      rdQ.push_back(32'h0000_0802); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL full_stat got %h exp %h", bus.ReadDataM, e); end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== txQ[0]) begin errors++;
         $display("FAIL full_head got %b/%h exp 1/%h",
                  tx_valid, tx_data, txQ[0]); end
      drive(1'b1, A_TXD, 32'h19, 1'b0);
      drive(1'b0, A_DROP, 32'h0, 1'b0);
      rdQ.push_back(32'd1); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL drop_cnt got %h exp %h", bus.ReadDataM, e); end
      bus.ALUResultM = A_STAT; #1;
      rdQ.push_back(32'h0000_0802); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL drop_stat got %h exp %h", bus.ReadDataM, e); end
      checks++;
      if (tx_data !== txQ[0]) begin errors++;
         $display("FAIL drop_head got %h exp %h", tx_data, txQ[0]); end
      bus.ALUResultM = A_TXD; #1;
      rdQ.push_back(32'h0); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL txd_read got %h exp %h", bus.ReadDataM, e); end
   endtask

   task automatic test_full_pop();
      logic [31:0] e;
      logic [7:0]  b;
      drive(1'b1, A_TXD, 32'h20, 1'b1);
      b = txQ.pop_front(); checks++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
         $display("FAIL fp_pop got %b/%h exp 1/%h", tx_valid, tx_data, b); end
      txQ.push_back(8'h20);
      for (int k = 0; k < 9; k++) begin
         drive(1'b0, A_STAT, 32'h0, 1'b1);
         if (k == 0) begin
            rdQ.push_back(32'h0000_0802); e = rdQ.pop_front(); checks++;
            if (bus.ReadDataM !== e) begin errors++;
               $display("FAIL fp_stat got %h exp %h", bus.ReadDataM, e); end
         end
         if (txQ.size() == 0) begin
            rdQ.push_back(32'h1); e = rdQ.pop_front(); checks++;
            if (tx_valid !== 1'b0 || bus.ReadDataM !== e) begin errors++;
               $display("FAIL fp_empty got %b/%h exp 0/%h",
                        tx_valid, bus.ReadDataM, e); end
         end else begin
            b = txQ.pop_front(); checks++;
            if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
               $display("FAIL fp_drain%0d got %b/%h exp 1/%h",
                        k, tx_valid, tx_data, b); end
         end
      end
      bus.ALUResultM = A_DROP; #1;
      rdQ.push_back(32'd1); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL fp_drop got %h exp %h", bus.ReadDataM, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      logic [7:0]  b;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, A_TXD, 32'h61 + 32'(i), 1'b1);
         if (i == 0) begin
            checks++;
            if (tx_valid !== 1'b0) begin errors++;
               $display("FAIL b2b_fallthru got %b exp 0", tx_valid); end
         end else begin
            b = txQ.pop_front(); checks++;
            if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
               $display("FAIL b2b_pop%0d got %b/%h exp 1/%h",
                        i, tx_valid, tx_data, b); end
         end
         txQ.push_back(8'h61 + 8'(i));
      end
      drive(1'b0, A_STAT, 32'h0, 1'b1);
      rdQ.push_back(32'h0000_0100); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL b2b_stat got %h exp %h", bus.ReadDataM, e); end
      b = txQ.pop_front(); checks++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
         $display("FAIL b2b_last got %b/%h exp 1/%h", tx_valid, tx_data, b); end
      drive(1'b0, A_STAT, 32'h0, 1'b1);
      rdQ.push_back(32'h1); e = rdQ.pop_front(); checks++;
      if (tx_valid !== 1'b0 || bus.ReadDataM !== e) begin errors++;
         $display("FAIL b2b_empty got %b/%h exp 0/%h",
                  tx_valid, bus.ReadDataM, e); end
   endtask

   task automatic test_mmio_misc();
      logic [31:0] e;
      drive(1'b1, 32'h8000_0018, 32'hFFFF_FFFF, 1'b0);
      drive(1'b0, 32'h8000_0018, 32'h0, 1'b0);
      rdQ.push_back(32'h0); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL rsv_read got %h exp %h", bus.ReadDataM, e); end
      drive(1'b1, A_STAT, 32'hFFFF, 1'b0);
      drive(1'b1, A_DROP, 32'h55, 1'b0);
      drive(1'b0, A_STAT, 32'h0, 1'b0);
      rdQ.push_back(32'h1); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ro_stat got %h exp %h", bus.ReadDataM, e); end
      bus.ALUResultM = A_DROP; #1;
      rdQ.push_back(32'd1); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ro_drop got %h exp %h", bus.ReadDataM, e); end
      drive(1'b1, 32'h8000_1000, 32'h3C, 1'b0);
      drive(1'b0, 32'h10, 32'h0, 1'b0);
      checks++;
      if (led_o !== 32'h3C) begin errors++;
         $display("FAIL led_alias got %h exp 3c", led_o); end
      rdQ.push_back(32'hDEAD_BEEF); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL ram_kept got %h exp %h", bus.ReadDataM, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      logic [7:0]  b;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, A_TXD, 32'hA1 + 32'(i), 1'b0);
         txQ.push_back(8'hA1 + 8'(i));
      end
      drive(1'b0, A_STAT, 32'h0, 1'b1);
      b = txQ.pop_front(); checks++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
         $display("FAIL rm_pop got %b/%h exp 1/%h", tx_valid, tx_data, b); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #2;
      txQ.delete();
      rdQ.push_back(32'h1); e = rdQ.pop_front(); checks++;
      if (tx_valid !== 1'b0 || bus.ReadDataM !== e) begin errors++;
         $display("FAIL rm_clear got %b/%h exp 0/%h",
                  tx_valid, bus.ReadDataM, e); end
      checks++;
      if (led_o !== 32'h0) begin errors++;
         $display("FAIL rm_led got %h exp 0", led_o); end
      bus.ALUResultM = A_DROP; #1;
      rdQ.push_back(32'h0); e = rdQ.pop_front(); checks++;
      if (bus.ReadDataM !== e) begin errors++;
         $display("FAIL rm_drop got %h exp %h", bus.ReadDataM, e); end
      drive(1'b1, A_TXD, 32'h55, 1'b1);
      txQ.push_back(8'h55);
      checks++;
      if (tx_valid !== 1'b0) begin errors++;
         $display("FAIL rm_push got %b exp 0", tx_valid); end
      drive(1'b0, A_STAT, 32'h0, 1'b1);
      b = txQ.pop_front(); checks++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin errors++;
         $display("FAIL rm_first got %b/%h exp 1/%h", tx_valid, tx_data, b); end
      drive(1'b0, A_STAT, 32'h0, 1'b1);
      checks++;
      if (tx_valid !== 1'b0) begin errors++;
         $display("FAIL rm_done got %b exp 0", tx_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ram();
      test_led();
      test_cycle();
      test_fifo_full();
      test_full_pop();
      test_back_to_back();
      test_mmio_misc();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
